// File: rtl/scan_debounce_ctrl_if.sv
// Signal bundle between the pad synchronizer side and the shared debounce engine.
interface scan_debounce_ctrl_if #(
   parameter int N_INPUTS = 6,
   parameter int SW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
);
   logic [N_INPUTS-1:0] raw;
   logic                freeze;
   logic [N_INPUTS-1:0] debounced;
   logic [N_INPUTS-1:0] rise;
   logic [N_INPUTS-1:0] fall;
   logic [SW-1:0]       slot;
   logic                strobe;

   modport master (
      output raw, freeze,
      input  debounced, rise, fall, slot, strobe
   );

   modport slave (
      input  raw, freeze,
      output debounced, rise, fall, slot, strobe
   );
endinterface

// File: rtl/scan_debounce_ctrl.sv
// Time-multiplexed debouncer: one shift-register datapath shared round-robin
// across N_INPUTS lines, paced by a prescaler strobe.
module scan_debounce_ctrl #(
   parameter int N_INPUTS = 6,
   parameter int HISTORY  = 8,
   parameter int TICK_DIV = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   scan_debounce_ctrl_if.slave   bus
);
   localparam int SW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(N_INPUTS - 1);

   logic [N_INPUTS-1:0]              sync1_q, sync_q;
   logic [PW-1:0]                    pre_q, pre_d;
   logic [SW-1:0]                    slot_q, slot_d;
   logic [N_INPUTS-1:0][HISTORY-1:0] hist_q, hist_d;
   logic [N_INPUTS-1:0]              deb_q, deb_d;
   logic [N_INPUTS-1:0]              rise_q, rise_d;
   logic [N_INPUTS-1:0]              fall_q, fall_d;
   logic [HISTORY-1:0]               hist_new;
   logic                             strobe_w;

   // Two-flop synchronizer. Left out of reset so that a level held through
   // reset is already visible on the first sample after release.
   always_ff @(posedge clk) begin
      sync1_q <= bus.raw;
      sync_q  <= sync1_q;
   end

   assign strobe_w = (pre_q == PRE_LAST) && !bus.freeze;
   assign hist_new = {hist_q[slot_q][HISTORY-2:0], sync_q[slot_q]};

   // Next-state: prescaler, slot pointer and the single history/level update per strobe.
   always_comb begin
      pre_d  = pre_q;
      slot_d = slot_q;
      hist_d = hist_q;
      deb_d  = deb_q;
      rise_d = '0;
      fall_d = '0;
      if (!bus.freeze) begin
         pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      end
      if (strobe_w) begin
         hist_d[slot_q] = hist_new;
         if ((&hist_new) && !deb_q[slot_q]) begin
            deb_d[slot_q]  = 1'b1;
            rise_d[slot_q] = 1'b1;
         end else if (!(|hist_new) && deb_q[slot_q]) begin
            deb_d[slot_q]  = 1'b0;
            fall_d[slot_q] = 1'b1;
         end
         slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      end
   end

   // State registers; reset drops everything without emitting fall events.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q  <= '0;
         slot_q <= '0;
         hist_q <= '0;
         deb_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         pre_q  <= pre_d;
         slot_q <= slot_d;
         hist_q <= hist_d;
         deb_q  <= deb_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign bus.debounced = deb_q;
   assign bus.rise      = rise_q;
   assign bus.fall      = fall_q;
   assign bus.slot      = slot_q;
   assign bus.strobe    = strobe_w;
endmodule
